ddr_rx_deserializer: RTL and testbench
======================================

# ddr_rx_deserializer

- Receive end of the team's 4-bit dual-edge data path: samples a DDR nibble stream on both clock edges and assembles one byte per clock.
- Hunts for a sync byte to find byte alignment, then forwards payload bytes through a small first-word-fall-through FIFO with a valid/ready handshake.
- Sits between the dual-edge transmit flops of the link and single-rate consumer logic.

## Interface
- SYNC_WORD, 8'hA5, alignment byte that opens a frame; it is never forwarded.
- DEPTH, 4, FIFO depth in bytes; must be a power of 2, ≥2.
- clk  input  1  single clock; DDR data is sampled on both its edges.
- rst  input  1  reset, synchronous, active-low.
- ddr_d  input  4  DDR nibble stream; high-phase nibble is sampled at the falling edge, low-phase nibble at the rising edge.
- ddr_en  input  1  frame enable, SDR, sampled at the rising edge.
- out_data  output  8  FIFO head byte.
- out_valid  output  1  out_data holds a valid byte.
- out_ready  input  1  consumer accepts the byte when out_valid && out_ready at a rising edge.
- locked  output  1  alignment state is LOCKED.
- ovf  output  1  sticky overflow: a byte was dropped because the FIFO was full.
- err_cnt  output  8  dropped-byte count. See Configuration.

## Operation
- **Capture**
  - neg_nib captures ddr_d at every falling edge.
  - Reset applies to neg_nib too, sampled at the falling edge.
  - At every rising edge: byte_raw = {neg_nib, ddr_d}. The MSB nibble is the falling-edge sample of the same cycle.
- **State machine** (rising edge):
  - HUNT: if ddr_en && byte_raw == SYNC_WORD, go to LOCKED. Nothing is pushed in HUNT.
  - LOCKED: if ddr_en, push byte_raw, including any later SYNC_WORD values. If !ddr_en, go to HUNT and push nothing that cycle.
- **FIFO**
  - Write and read pointers are log2(DEPTH)+1 bits wide, with wrap bit.
  - Full when the pointers differ only in the MSB; empty when they are equal.
  - First-word-fall-through: out_data = mem[rd_ptr].
  - out_valid = !empty.
  - out_data is don't-care when out_valid = 0.
- **Push when full, no pop that cycle**
  - The byte is dropped.
  - ovf is set to 1 and stays set until reset.
  - err_cnt increments.
- **Push and pop in the same cycle**
  - Both succeed, including when full. No drop and no ovf.
  - A push on empty with out_ready = 1 does not bypass. The byte becomes visible the next cycle.
- **Reset** (rst = 0 at a rising edge), applies mid-frame as well:
  - State goes to HUNT and both pointers are cleared, so in-flight bytes are discarded.
  - Outputs: out_valid = 0, locked = 0, ovf = 0, err_cnt = 0.
  - out_data is don't-care.

## Timing
- Latency from the rising edge that forms a payload byte to out_valid = 1 is one edge: the byte is visible right after that edge.
- Throughput is 1 byte per clock in and 1 byte per clock out.
- The SYNC_WORD byte is detected at rising edge N, and locked = 1 after edge N. The first payload byte is formed at edge N+1.
- When ddr_en falls:
  - locked drops after the first rising edge that samples ddr_en = 0.
  - Bytes already queued remain readable.
- Sync matching is exact. There is no error tolerance and no nibble-slip search: alignment is fixed by the edge pairing.

## Configuration
- DDR_RX_ERRCNT_EN defined:
  - err_cnt is an 8-bit counter of dropped bytes.
  - It saturates at 8'hFF and clears only on reset.
- Not defined:
  - err_cnt is tied to 8'h00 and no counter logic is built.
  - ovf behaves the same in both builds.

## Test plan
- **Reset, then lock:** hold rst = 0 for 2 cycles, then release; drive ddr_en = 1 with nibbles A,5 (falling edge, then rising edge) followed by 1,2 and 3,4.
  - After reset: locked = 0, out_valid = 0.
  - Then: locked = 1, out_data = 8'h12 then 8'h34; SYNC_WORD 8'hA5 is never output.
- **Hunt rejection:** send bytes 8'hA4, 8'h5A, 8'hFF with ddr_en = 1.
  - locked stays 0 and out_valid stays 0.
- **Overflow:** with DEPTH = 4 and out_ready = 0, lock, then send 6 payload bytes 01..06.
  - FIFO holds 01..04 and ovf = 1.
  - err_cnt = 2 with the macro defined, 0 without.
  - Draining yields 01,02,03,04, then out_valid = 0.
- **Simultaneous push/pop at full:** FIFO full with 01..04, out_ready = 1, push 05.
  - 01 is popped, 05 is accepted, ovf stays 0.
  - Subsequent output order is 02,03,04,05.
- **Frame end:** deassert ddr_en after 2 payload bytes.
  - locked = 0 after that edge and further bytes are ignored.
  - The 2 queued bytes still drain.
- **Reset mid-frame:** assert rst = 0 with 3 bytes queued while locked.
  - After the edge: out_valid = 0, locked = 0, ovf = 0, err_cnt = 0.
  - Re-sync with SYNC_WORD then works.

Source files
------------

// File: rtl/ddr_rx_if.sv
// Handshake/bus bundle for the DDR receive deserializer: DDR nibble input,
// FWFT byte output with valid/ready, and link status.
interface ddr_rx_if;
  logic [3:0] ddr_d;
  logic       ddr_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       locked;
  logic       ovf;
  logic [7:0] err_cnt;

  modport master (
    output ddr_d, ddr_en, out_ready,
    input  out_data, out_valid, locked, ovf, err_cnt
  );

  modport slave (
    input  ddr_d, ddr_en, out_ready,
    output out_data, out_valid, locked, ovf, err_cnt
  );
endinterface

// File: rtl/ddr_rx_deserializer.sv
// DDR nibble-to-byte receiver: sync-word hunt, then payload into a FWFT FIFO.
// Optional DDR_RX_ERRCNT_EN builds a saturating dropped-byte counter on err_cnt.
module ddr_rx_deserializer #(
  parameter logic [7:0] SYNC_WORD = 8'hA5,
  parameter int         DEPTH     = 4
) (
  input  logic    i_clk,
  input  logic    i_rst,
  ddr_rx_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           r_state;
  logic [3:0]       r_neg_nib;
  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic             r_ovf;

  logic [7:0] w_byte_raw;
  logic       w_full, w_empty, w_push, w_pop, w_drop;

  // High-phase nibble, held until the following rising edge pairs it.
  always_ff @(negedge i_clk) begin
    if (!i_rst) r_neg_nib <= 4'h0;
    else        r_neg_nib <= bus.ddr_d;
  end

  assign w_byte_raw = {r_neg_nib, bus.ddr_d};
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr == {~r_rd_ptr[PTR_W-1], r_rd_ptr[AW-1:0]});
  assign w_pop      = !w_empty && bus.out_ready;
  assign w_push     = (r_state == LOCKED) && bus.ddr_en;
  // A full FIFO still accepts a push when the head is popped on the same edge.
  assign w_drop     = w_push && w_full && !w_pop;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state  <= HUNT;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        HUNT:    if (bus.ddr_en && w_byte_raw == SYNC_WORD) r_state <= LOCKED;
        LOCKED:  if (!bus.ddr_en) r_state <= HUNT;
        default: r_state <= HUNT;
      endcase
      if (w_push && !w_drop) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)             r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop)            r_ovf    <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !w_drop) r_mem[r_wr_ptr[AW-1:0]] <= w_byte_raw;
  end

`ifdef DDR_RX_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst)                          r_err_cnt <= 8'h00;
    else if (w_drop && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign bus.err_cnt = r_err_cnt;
`else
  assign bus.err_cnt = 8'h00;
`endif

  assign bus.out_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign bus.out_valid = !w_empty;
  assign bus.locked    = (r_state == LOCKED);
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_ddr_rx_deserializer.sv
// Directed bench for ddr_rx_deserializer: lock, hunt rejection, overflow,
// push/pop at full, frame end and mid-frame reset.
module tb_ddr_rx_deserializer;
  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  ddr_rx_if bus ();

  ddr_rx_deserializer #(.SYNC_WORD(8'hA5), .DEPTH(4)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  always #5 i_clk = ~i_clk;

`ifdef DDR_RX_ERRCNT_EN
  localparam logic [7:0] EXP_ERR = 8'd2;
`else
  localparam logic [7:0] EXP_ERR = 8'd0;
`endif

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One byte per clock: hi nibble held across the falling edge, lo across the rising edge.
  // Entered and left 1 time unit after a rising edge.
  task automatic step(input logic [3:0] hi, input logic [3:0] lo, input logic en);
    bus.ddr_d  = hi;
    bus.ddr_en = en;
    @(negedge i_clk);
    #1 bus.ddr_d = lo;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input logic v, input logic l,
                            input logic o, input logic [7:0] e);
    chk({tag, ".valid"},  {7'd0, bus.out_valid}, {7'd0, v});
    chk({tag, ".locked"}, {7'd0, bus.locked},    {7'd0, l});
    chk({tag, ".ovf"},    {7'd0, bus.ovf},       {7'd0, o});
    chk({tag, ".err"},    bus.err_cnt,           e);
  endtask

  initial begin
    bus.ddr_d     = 4'h0;
    bus.ddr_en    = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge i_clk);
    #1;
    // Reset for two cycles
    step(4'h0, 4'h0, 1'b0);
    step(4'h0, 4'h0, 1'b0);
    chk_status("reset", 1'b0, 1'b0, 1'b0, 8'h00);
    i_rst = 1'b1;

    // Lock then two payload bytes
    step(4'hA, 4'h5, 1'b1);
    chk_status("sync", 1'b0, 1'b1, 1'b0, 8'h00);
    step(4'h1, 4'h2, 1'b1);
    chk("lock.v1", {7'd0, bus.out_valid}, 8'd1);
    chk("lock.d1", bus.out_data, 8'h12);
    step(4'h3, 4'h4, 1'b1);
    chk("lock.head", bus.out_data, 8'h12);
    bus.out_ready = 1'b1;
    step(4'h0, 4'h0, 1'b0);
    chk("lock.d2", bus.out_data, 8'h34);
    chk("lock.drop", {7'd0, bus.locked}, 8'd0);
    step(4'h0, 4'h0, 1'b0);
    chk("lock.empty", {7'd0, bus.out_valid}, 8'd0);
    bus.out_ready = 1'b0;

    // Hunt rejects near-miss patterns
    step(4'hA, 4'h4, 1'b1);
    chk_status("hunt.a4", 1'b0, 1'b0, 1'b0, 8'h00);
    step(4'h5, 4'hA, 1'b1);
    chk_status("hunt.5a", 1'b0, 1'b0, 1'b0, 8'h00);
    step(4'hF, 4'hF, 1'b1);
    chk_status("hunt.ff", 1'b0, 1'b0, 1'b0, 8'h00);

    // Overflow: 6 bytes into a 4-deep FIFO with no reads
    step(4'hA, 4'h5, 1'b1);
    for (int i = 1; i <= 6; i++) step(4'h0, 4'(i), 1'b1);
    chk_status("ovf", 1'b1, 1'b1, 1'b1, EXP_ERR);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("ovf.drain", bus.out_data, 8'(i));
      step(4'h0, 4'h0, 1'b0);
    end
    chk_status("ovf.end", 1'b0, 1'b0, 1'b1, EXP_ERR);
    bus.out_ready = 1'b0;
    i_rst = 1'b0;
    step(4'h0, 4'h0, 1'b0);
    i_rst = 1'b1;
    chk_status("ovf.rst", 1'b0, 1'b0, 1'b0, 8'h00);

    // Push and pop on the same edge while full
    step(4'hA, 4'h5, 1'b1);
    for (int i = 1; i <= 4; i++) step(4'h0, 4'(i), 1'b1);
    chk("full.head", bus.out_data, 8'h01);
    bus.out_ready = 1'b1;
    step(4'h0, 4'h5, 1'b1);
    chk("full.ovf", {7'd0, bus.ovf}, 8'd0);
    for (int i = 2; i <= 5; i++) begin
      chk("full.drain", bus.out_data, 8'(i));
      step(4'h0, 4'h0, 1'b0);
    end
    chk_status("full.end", 1'b0, 1'b0, 1'b0, 8'h00);
    bus.out_ready = 1'b0;

    // Frame end: bytes after ddr_en falls are ignored, queue still drains
    step(4'hA, 4'h5, 1'b1);
    step(4'h0, 4'h7, 1'b1);
    step(4'h0, 4'h8, 1'b1);
    step(4'h0, 4'h9, 1'b0);
    chk("fe.locked", {7'd0, bus.locked}, 8'd0);
    step(4'h1, 4'h1, 1'b1);
    chk("fe.locked2", {7'd0, bus.locked}, 8'd0);
    bus.out_ready = 1'b1;
    chk("fe.d1", bus.out_data, 8'h07);
    step(4'h0, 4'h0, 1'b0);
    chk("fe.d2", bus.out_data, 8'h08);
    step(4'h0, 4'h0, 1'b0);
    chk("fe.empty", {7'd0, bus.out_valid}, 8'd0);
    bus.out_ready = 1'b0;

    // Reset mid-frame with three bytes queued, then re-sync
    step(4'hA, 4'h5, 1'b1);
    step(4'h2, 4'h1, 1'b1);
    step(4'h2, 4'h2, 1'b1);
    step(4'h2, 4'h3, 1'b1);
    chk_status("mid.pre", 1'b1, 1'b1, 1'b0, 8'h00);
    i_rst = 1'b0;
    step(4'h0, 4'h0, 1'b1);
    i_rst = 1'b1;
    chk_status("mid.rst", 1'b0, 1'b0, 1'b0, 8'h00);
    step(4'hA, 4'h5, 1'b1);
    chk("resync.locked", {7'd0, bus.locked}, 8'd1);
    step(4'h6, 4'h6, 1'b1);
    chk("resync.valid", {7'd0, bus.out_valid}, 8'd1);
    chk("resync.data", bus.out_data, 8'h66);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
